// File: rtl/timing_step_decoder_pkg.sv
// Shared definitions for the multicycle timing-step generator: default
// counter width, reset step, done idle level and named step encodings
// (SEL_W=4) used by the control decode.
package timing_step_decoder_pkg;

  localparam int DEF_SEL_W      = 4;
  localparam int DEF_RESET_STEP = 0;
  localparam logic DONE_IDLE    = 1'b0;

  typedef logic [DEF_SEL_W-1:0] step4_t;

  localparam step4_t T0  = 4'd0;
  localparam step4_t T1  = 4'd1;
  localparam step4_t T2  = 4'd2;
  localparam step4_t T3  = 4'd3;
  localparam step4_t T4  = 4'd4;
  localparam step4_t T5  = 4'd5;
  localparam step4_t T6  = 4'd6;
  localparam step4_t T7  = 4'd7;
  localparam step4_t T8  = 4'd8;
  localparam step4_t T9  = 4'd9;
  localparam step4_t T10 = 4'd10;
  localparam step4_t T11 = 4'd11;
  localparam step4_t T12 = 4'd12;
  localparam step4_t T13 = 4'd13;
  localparam step4_t T14 = 4'd14;
  localparam step4_t T15 = 4'd15;

endpackage

// File: rtl/timing_step_decoder_dec_n.sv
// Parametrised SEL_W-to-2^SEL_W one-hot decoder with enable.
// Output is all zeros when disabled; never more than one bit set.
module dec_n #(
  parameter int  SEL_W = 4,
  localparam int N_OUT = 2**SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] y
);

  // Decode the select into a single strobe, zeros by default
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/timing_step_decoder.sv
// Timing-state generator: a step counter with clear/load/stall/enable
// priority, a wrap-on-terminal-step rule and a registered done pulse,
// feeding an enable-gated one-hot decoder that produces T0..Tn strobes.
module timing_step_decoder
  import timing_step_decoder_pkg::*;
#(
  parameter int  SEL_W      = DEF_SEL_W,
  parameter int  RESET_STEP = DEF_RESET_STEP,
  localparam int N_OUT      = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             clr,
  input  logic             load,
  input  logic [SEL_W-1:0] load_step,
  input  logic [SEL_W-1:0] last_step,
  output logic [SEL_W-1:0] step,
  output logic [N_OUT-1:0] t_out,
  output logic             done
);

  localparam logic [SEL_W-1:0] RST_VAL = SEL_W'(RESET_STEP);

  logic [SEL_W-1:0] step_nxt;
  logic             done_nxt;

  // Next step in priority order: clear, load, hold, then advance/wrap.
  // The >= compare makes a terminal step lowered below the current step
  // wrap on the next advance instead of running on to N_OUT-1.
  always_comb begin
    step_nxt = step;
    done_nxt = DONE_IDLE;
    if (clr) begin
      step_nxt = RST_VAL;
    end else if (load) begin
      step_nxt = load_step;
    end else if (en && !stall) begin
      if (step >= last_step) begin
        step_nxt = '0;
        done_nxt = 1'b1;
      end else begin
        step_nxt = step + 1'b1;
      end
    end
  end

  // Step and done registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= RST_VAL;
      done <= DONE_IDLE;
    end else begin
      step <= step_nxt;
      done <= done_nxt;
    end
  end

  dec_n #(.SEL_W(SEL_W)) u_dec (
    .en  (en),
    .sel (step),
    .y   (t_out)
  );

endmodule

// File: tb/tb_timing_step_decoder.sv
// Bench for timing_step_decoder: SEL_W=4 and SEL_W=3 instances share the
// control inputs and are checked every cycle against a step/done model.
module tb_timing_step_decoder;

  logic       clk = 1'b0;
  logic       rst, en, stall, clr, load;
  logic [3:0] ld4, last4, step4;
  logic [2:0] ld3, last3, step3;
  logic [15:0] t4;
  logic [7:0]  t3;
  logic        done4, done3;

  int total = 0;
  int bad   = 0;
  int ms [2];
  bit md [2];

  always #5 clk = ~clk;

  timing_step_decoder #(.SEL_W(4), .RESET_STEP(0)) dut4 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .clr(clr), .load(load),
    .load_step(ld4), .last_step(last4), .step(step4), .t_out(t4), .done(done4)
  );

  timing_step_decoder #(.SEL_W(3), .RESET_STEP(0)) dut3 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .clr(clr), .load(load),
    .load_step(ld3), .last_step(last3), .step(step3), .t_out(t3), .done(done3)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i] = 0;
      md[i] = 1'b0;
    end
  endtask

  task automatic model_edge_one(int i, int w, int last, int ld);
    if (rst) begin
      ms[i] = 0; md[i] = 1'b0;
    end else if (clr) begin
      ms[i] = 0; md[i] = 1'b0;
    end else if (load) begin
      ms[i] = ld; md[i] = 1'b0;
    end else if (!en || stall) begin
      md[i] = 1'b0;
    end else if (ms[i] >= last) begin
      ms[i] = 0; md[i] = 1'b1;
    end else begin
      ms[i] = (ms[i] + 1) % (1 << w); md[i] = 1'b0;
    end
  endtask

  task automatic chk(string tag);
    logic [15:0] e4;
    logic [7:0]  e3;
    e4 = en ? (16'd1 << ms[0]) : 16'd0;
    e3 = en ? (8'd1 << ms[1]) : 8'd0;
    total++;
    assert (step4 === 4'(ms[0])) else begin bad++; $error("FAIL %s step4 got=%0d exp=%0d", tag, step4, ms[0]); end
    total++;
    assert (t4 === e4) else begin bad++; $error("FAIL %s t4 got=%h exp=%h", tag, t4, e4); end
    total++;
    assert (done4 === md[0]) else begin bad++; $error("FAIL %s done4 got=%b exp=%b", tag, done4, md[0]); end
    total++;
    assert ($onehot0(t4)) else begin bad++; $error("FAIL %s t4_onehot got=%h exp=onehot0", tag, t4); end
    total++;
    assert (step3 === 3'(ms[1])) else begin bad++; $error("FAIL %s step3 got=%0d exp=%0d", tag, step3, ms[1]); end
    total++;
    assert (t3 === e3) else begin bad++; $error("FAIL %s t3 got=%h exp=%h", tag, t3, e3); end
    total++;
    assert (done3 === md[1]) else begin bad++; $error("FAIL %s done3 got=%b exp=%b", tag, done3, md[1]); end
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_edge_one(0, 4, int'(last4), int'(ld4));
    model_edge_one(1, 3, int'(last3), int'(ld3));
    #1;
    chk(tag);
  endtask

  task automatic expect4(string tag, logic [3:0] s, logic [15:0] t, logic d);
    total++;
    assert (step4 === s && t4 === t && done4 === d) else begin
      bad++;
      $error("FAIL %s got step=%0d t=%h done=%b exp step=%0d t=%h done=%b", tag, step4, t4, done4, s, t, d);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; clr = 1'b0; load = 1'b0;
    ld4 = '0; last4 = 4'd15; ld3 = '0; last3 = 3'd7;
    model_reset();

    // reset state and decode while reset is held
    #2; chk("rst_en0");
    expect4("rst_en0_k", 4'd0, 16'h0000, 1'b0);
    en = 1'b1; #1; chk("rst_en1");
    expect4("rst_en1_k", 4'd0, 16'h0001, 1'b0);
    cyc("rst_hold");
    rst = 1'b0;

    // full 16-step run and wrap
    for (int i = 0; i < 15; i++) cyc("run16");
    expect4("run16_last", 4'd15, 16'h8000, 1'b0);
    cyc("wrap16");
    expect4("wrap16_k", 4'd0, 16'h0001, 1'b1);
    cyc("after_wrap");
    expect4("after_wrap_k", 4'd1, 16'h0002, 1'b0);

    // short instruction, then lower last_step below current step
    last4 = 4'd3; last3 = 3'd3;
    for (int i = 0; i < 20 && ms[0] != 3; i++) cyc("to3");
    expect4("short_t3", 4'd3, 16'h0008, 1'b0);
    cyc("short_wrap");
    expect4("short_wrap_k", 4'd0, 16'h0001, 1'b1);
    for (int i = 0; i < 20 && ms[0] != 3; i++) cyc("to3b");
    last4 = 4'd1; last3 = 3'd1;
    cyc("lower_last");
    expect4("lower_last_k", 4'd0, 16'h0001, 1'b1);

    // stall at step 2, then enable low, then release
    last4 = 4'd15; last3 = 3'd7;
    for (int i = 0; i < 20 && ms[0] != 2; i++) cyc("to2");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("stall");
    expect4("stall_k", 4'd2, 16'h0004, 1'b0);
    stall = 1'b0; en = 1'b0;
    #1; chk("en0_comb");
    for (int i = 0; i < 2; i++) cyc("en0");
    expect4("en0_k", 4'd2, 16'h0000, 1'b0);
    en = 1'b1;
    cyc("release");
    expect4("release_k", 4'd3, 16'h0008, 1'b0);

    // load, clr beats load, load beats stall
    load = 1'b1; ld4 = 4'd9; ld3 = 3'd1;
    cyc("load9");
    expect4("load9_k", 4'd9, 16'h0200, 1'b0);
    clr = 1'b1;
    cyc("clr_load");
    expect4("clr_load_k", 4'd0, 16'h0001, 1'b0);
    clr = 1'b0; stall = 1'b1; ld4 = 4'd5; ld3 = 3'd5;
    cyc("load_stall");
    expect4("load_stall_k", 4'd5, 16'h0020, 1'b0);
    load = 1'b0; stall = 1'b0;

    // stall during terminal step: hold, no done
    last4 = 4'd7; last3 = 3'd7;
    for (int i = 0; i < 20 && ms[0] != 7; i++) cyc("to7");
    stall = 1'b1;
    for (int i = 0; i < 2; i++) cyc("stall_term");
    expect4("stall_term_k", 4'd7, 16'h0080, 1'b0);
    stall = 1'b0;
    cyc("term_wrap");
    expect4("term_wrap_k", 4'd0, 16'h0001, 1'b1);

    // asynchronous reset between edges at step 6
    for (int i = 0; i < 20 && ms[0] != 6; i++) cyc("to6");
    #3; rst = 1'b1; #1;
    model_reset();
    chk("async_rst");
    expect4("async_rst_k", 4'd0, 16'h0001, 1'b0);
    cyc("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc("restart");
    expect4("restart_k", 4'd3, 16'h0008, 1'b0);

    // SEL_W=3 instance: step 7 wraps to 0 with done
    for (int i = 0; i < 20 && ms[1] != 7; i++) cyc("to7_w3");
    total++;
    assert (t3 === 8'h80) else begin bad++; $error("FAIL w3_t7 got=%h exp=%h", t3, 8'h80); end
    cyc("w3_wrap");
    total++;
    assert (step3 === 3'd0 && done3 === 1'b1) else begin
      bad++; $error("FAIL w3_wrap got step=%0d done=%b exp step=0 done=1", step3, done3);
    end

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 5) == 0);
      clr   = ($urandom_range(0, 29) == 0);
      load  = ($urandom_range(0, 19) == 0);
      ld4   = 4'($urandom_range(0, 15));
      ld3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        last4 = 4'($urandom_range(0, 15));
        last3 = 3'($urandom_range(0, 7));
      end
      #1; chk("rand_comb");
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timing_step_decoder.md
Name: timing_step_decoder

Overview:
- Parametrised timing-state generator for the multicycle control path: a step counter drives an SEL_W-to-2^SEL_W enable-gated one-hot decoder, producing T0..Tn timing strobes.
- Generalises the fixed 4-to-16 enable decoder in three ways: selectable width, a per-instruction terminal step, and stall, clear and load control.
- Sits between the instruction decode logic, which supplies last_step, and the datapath control-signal generation, which consumes t_out.

Parameters:
- SEL_W, 4, width of the step counter; the decoder produces 2**SEL_W outputs.
- N_OUT, 2**SEL_W, derived localparam (number of one-hot outputs). Not overridable.
- RESET_STEP, 0, step value loaded on reset and on clr. Must be < N_OUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global enable: gates both t_out and advancing
- stall  in  1  holds the current step (wait state, e.g. memory not ready)
- clr  in  1  synchronous restart to RESET_STEP
- load  in  1  synchronous jump to load_step
- load_step  in  SEL_W  target step for load
- last_step  in  SEL_W  terminal step of the current instruction
- step  out  SEL_W  current step register
- t_out  out  N_OUT  one-hot timing strobes: t_out[k]=1 iff step==k and en=1
- done  out  1  one-cycle pulse marking completion of a sequence

Behaviour:
- Reset (async, rst=1):
  - step=RESET_STEP, done=0.
  - t_out follows the decode rule immediately (bit RESET_STEP set if en=1, else all 0).
- Decode:
  - t_out is combinational from the step register and en; zero latency from step.
  - With en=0, t_out is all zeros.
  - t_out is exactly one-hot or all-zero in every cycle; never multi-hot.
- Step update at each rising clk edge when rst=0, in strict priority:
  1. clr=1: step←RESET_STEP, done←0. Ignores en and stall.
  2. load=1: step←load_step, done←0. Ignores en and stall.
  3. en=0 or stall=1: step holds, done←0.
  4. Advance:
     - If step >= last_step: step←0, done←1.
     - Otherwise: step←step+1, done←0.
- done:
  - Registered. High exactly for the cycle after a wrapping advance.
  - Back-to-back wraps (last_step=0, continuous advance) hold done high every cycle.
- Boundary conditions:
  - last_step changed mid-sequence to a value below step: the next advance wraps to 0 and pulses done. The counter never runs past N_OUT-1 looking for a match.
  - last_step=N_OUT-1: the counter wraps naturally from N_OUT-1 to 0 with done=1.
  - load_step > last_step is accepted; the next advance wraps.
  - clr and load together: clr wins.
  - stall during the terminal step: hold T(last_step), no done, until stall drops.
  - Reset asserted mid-sequence: immediate return to RESET_STEP, done=0, no glitch pulse.
- Arithmetic and width:
  - All comparisons are unsigned, SEL_W bits.
  - Increment is modulo 2**SEL_W.
  - No X propagation: the default decode branch drives zeros.

Decomposition:
- Shared header seq_defs.vh holds:
  - default SEL_W;
  - named step constants T0..T15 (SEL_W=4 encodings) used by control decode;
  - DONE/RESET_STEP defaults.
- One sub-module, dec_n: a parametrised combinational SEL_W-to-2^SEL_W decoder with enable. It replaces the fixed 16-output decoder and is instantiated once for t_out.
- The counter, priority logic and done register live in timing_step_decoder.

Test Plan:
- Reset and decode, SEL_W=4, en=1, last_step=15, no stall:
  - Release rst; step runs 0..15 over 16 cycles, t_out = 16'h0001, 0002 … 8000.
  - Wrap to 0 with done=1 for exactly one cycle.
  - t_out checked for one-hot every cycle.
- Short instruction, last_step=3:
  - Sequence is 0,1,2,3,0 with done high in the cycle step returns to 0.
  - Change last_step to 1 while step=3: the next advance wraps to 0 with a done pulse.
- Stall and enable:
  - stall=1 at step=2 for 3 cycles: step stays 2, t_out=16'h0004, done=0.
  - en=0 for 2 cycles: t_out=16'h0000 and step held.
  - Both release: the next edge gives step=3.
- clr/load priority:
  - load=1, load_step=9 → step=9.
  - clr=1 and load=1 together → step=RESET_STEP (0).
  - With stall=1, load_step=5 still loads 5.
- Async reset mid-run, last_step=7:
  - Assert rst between edges at step=6: step=0 and done=0 immediately, with no clock.
  - After release, the sequence restarts at 0.
- Parametric, SEL_W=3:
  - t_out is 8 bits.
  - last_step=7 wraps 7→0 with done; all 8 outputs are exercised.
